// File: rtl/sig_normalizer_pkg.sv
// ---------------------------------------------------------------------------
// fpu_unpack_pkg
// Shared constants and types for the significand normalizer.
//   DBL_BIAS / SGL_BIAS : IEEE-754 exponent biases
//   SIG_W               : unpacked significand width (hidden bit at SIG_W-1)
//   LZ_W                : leading-zero count width
//   norm_state_t        : normalizer FSM states
//   clamp_lz()          : limits a leading-zero count to the useful range
// ---------------------------------------------------------------------------
package fpu_unpack_pkg;

    localparam int DBL_BIAS = 1023;
    localparam int SGL_BIAS = 127;
    localparam int SIG_W    = 53;
    localparam int LZ_W     = 6;

    // Largest shift that still leaves a set bit inside the significand.
    localparam logic [LZ_W-1:0] LZ_MAX = LZ_W'(SIG_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } norm_state_t;

    function automatic logic [LZ_W-1:0] clamp_lz(input logic [LZ_W-1:0] lz);
        return (lz > LZ_MAX) ? LZ_MAX : lz;
    endfunction

endpackage

// File: rtl/sig_normalizer_if.sv
// ---------------------------------------------------------------------------
// sig_normalizer_if
// Operand and result handshake bundle for sig_normalizer.
//   in_valid/in_ready   : operand handshake (db, f, lz, e, e_z, fz)
//   out_valid/out_ready : result handshake (fn, en, zero)
// Modports: slave = the normalizer, master = the upstream/downstream driver.
// Parameter EW: width of the signed output exponent.
// ---------------------------------------------------------------------------
interface sig_normalizer_if #(
    parameter int EW = 13
);
    import fpu_unpack_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic                 db;
    logic [SIG_W-1:0]     f;
    logic [LZ_W-1:0]      lz;
    logic [10:0]          e;
    logic                 e_z;
    logic                 fz;
    logic                 out_valid;
    logic                 out_ready;
    logic [SIG_W-1:0]     fn;
    logic signed [EW-1:0] en;
    logic                 zero;

    modport slave (
        input  in_valid, db, f, lz, e, e_z, fz, out_ready,
        output in_ready, out_valid, fn, en, zero
    );

    modport master (
        output in_valid, db, f, lz, e, e_z, fz, out_ready,
        input  in_ready, out_valid, fn, en, zero
    );

endinterface

// File: rtl/sig_normalizer_shift_stage.sv
// ---------------------------------------------------------------------------
// sig_shift_stage
// Combinational bounded left shifter: shifts fn_i by min(rem_i, SHIFT_STEP)
// and returns the shifted significand plus the remaining shift count.
//   fn_i  / fn_o  : significand before / after this step
//   rem_i / rem_o : remaining shift before / after this step
// Parameter SHIFT_STEP: largest shift applied in one step (1..53).
// ---------------------------------------------------------------------------
module sig_shift_stage
    import fpu_unpack_pkg::*;
#(
    parameter int SHIFT_STEP = 16
) (
    input  logic [SIG_W-1:0] fn_i,
    input  logic [LZ_W-1:0]  rem_i,
    output logic [SIG_W-1:0] fn_o,
    output logic [LZ_W-1:0]  rem_o
);

    localparam logic [LZ_W-1:0] STEP = LZ_W'(SHIFT_STEP);

    logic [LZ_W-1:0] amt;

    always_comb begin
        amt   = (rem_i < STEP) ? rem_i : STEP;
        fn_o  = fn_i << amt;
        rem_o = rem_i - amt;
    end

endmodule

// File: rtl/sig_normalizer.sv
// ---------------------------------------------------------------------------
// sig_normalizer
// Normalizes unpacked significands: subnormals are left-shifted until the
// hidden bit reaches bit 52, and the raw exponent is turned into a signed
// unbiased exponent. Shifting is iterative, at most SHIFT_STEP bits/cycle.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : sig_normalizer_if.slave (operand in, result out, valid/ready)
// Parameters: SHIFT_STEP (1..53), EW (output exponent width).
// Build option SIG_NORM_FAST_EN: full barrel shift at accept, so SHIFT is
// never entered and latency is always one cycle; results are identical.
// ---------------------------------------------------------------------------
module sig_normalizer
    import fpu_unpack_pkg::*;
#(
    parameter int SHIFT_STEP = 16,
    parameter int EW         = 13
) (
    input logic             clk,
    input logic             rst,
    sig_normalizer_if.slave bus
);

    norm_state_t          state_q, state_d;
    logic [SIG_W-1:0]     fn_q, fn_d, fn_load, fn_step;
    logic [LZ_W-1:0]      rem_q, rem_d, rem_load, rem_step, lz_c;
    logic signed [EW-1:0] en_q, en_d, en_load;
    logic                 zero_q, zero_d, zero_load;
    logic                 subnormal, accept;
    logic [EW-1:0]        bias, e_eff;

    sig_shift_stage #(
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift (
        .fn_i  (fn_q),
        .rem_i (rem_q),
        .fn_o  (fn_step),
        .rem_o (rem_step)
    );

    // Operand decode: everything the registers need on an accept edge.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        lz_c      = clamp_lz(bus.lz);
        subnormal = bus.e_z & ~bus.fz;
        zero_load = bus.e_z & bus.fz;
        bias      = bus.db ? EW'(DBL_BIAS) : EW'(SGL_BIAS);
        // Single precision keeps its exponent in [7:0]; upper bits are junk.
        e_eff     = bus.db ? EW'(bus.e) : EW'(bus.e[7:0]);
        fn_load   = bus.f;
        rem_load  = '0;
        en_load   = e_eff - bias;
        if (zero_load) begin
            fn_load = '0;
            en_load = '0;
        end else if (subnormal) begin
            // Subnormals behave as exponent 1, minus the normalizing shift.
            en_load = EW'(1) - bias - EW'(lz_c);
`ifdef SIG_NORM_FAST_EN
            fn_load = bus.f << lz_c;
`else
            rem_load = lz_c;
`endif
        end
    end

    // Output process.
    always_comb begin
        bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
        bus.out_valid = (state_q == DONE);
    end

    assign accept   = bus.in_valid & bus.in_ready;
    assign bus.fn   = fn_q;
    assign bus.en   = en_q;
    assign bus.zero = zero_q;

    // Next-state process.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = (rem_load != '0) ? SHIFT : DONE;
            SHIFT: if (rem_step == '0) state_d = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    // Back-to-back: a new operand may replace the drained one.
                    if (accept) state_d = (rem_load != '0) ? SHIFT : DONE;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values. Accept never coincides with SHIFT (in_ready=0).
    always_comb begin
        fn_d   = fn_q;
        rem_d  = rem_q;
        en_d   = en_q;
        zero_d = zero_q;
        if (accept) begin
            fn_d   = fn_load;
            rem_d  = rem_load;
            en_d   = en_load;
            zero_d = zero_load;
        end else if (state_q == SHIFT) begin
            fn_d  = fn_step;
            rem_d = rem_step;
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            fn_q    <= '0;
            rem_q   <= '0;
            en_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fn_q    <= fn_d;
            rem_q   <= rem_d;
            en_q    <= en_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_sig_normalizer.sv
// ---------------------------------------------------------------------------
// tb_sig_normalizer
// Self-checking bench for sig_normalizer: directed vector table, hand-written
// backpressure and mid-shift reset sequences, and random operands checked
// against an arithmetic reference model. Honors SIG_NORM_FAST_EN (latency).
// ---------------------------------------------------------------------------
module tb_sig_normalizer;
    import fpu_unpack_pkg::*;

    localparam int STEP = 16;
    localparam int EW   = 13;
`ifdef SIG_NORM_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [52:0] ONE52 = 53'd1 << 52;

    typedef struct {
        bit          db;
        logic [52:0] f;
        logic [5:0]  lz;
        logic [10:0] e;
        bit          e_z;
        bit          fz;
    } stim_t;

    typedef struct {
        logic [52:0] fn;
        int          en;
        bit          zero;
        int          lat;
    } res_t;

    typedef struct {
        string name;
        stim_t s;
        res_t  x;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    sig_normalizer_if #(.EW(EW)) bus ();

    sig_normalizer #(
        .SHIFT_STEP (STEP),
        .EW         (EW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the normalization rules in plain integer arithmetic.
    function automatic res_t model(input stim_t s);
        res_t r;
        int   bias;
        int   lzc;
        bias = s.db ? 1023 : 127;
        if (s.e_z && s.fz) begin
            r.fn = '0; r.en = 0; r.zero = 1'b1; r.lat = 1;
        end else if (s.e_z) begin
            lzc    = (int'(s.lz) > 52) ? 52 : int'(s.lz);
            r.fn   = s.f << lzc;
            r.en   = 1 - bias - lzc;
            r.zero = 1'b0;
            r.lat  = FAST ? 1 : 1 + (lzc + STEP - 1) / STEP;
        end else begin
            r.fn   = s.f;
            r.en   = (s.db ? int'(s.e) : int'(s.e[7:0])) - bias;
            r.zero = 1'b0;
            r.lat  = 1;
        end
        return r;
    endfunction

    function automatic stim_t rand_stim();
        stim_t       s;
        logic [63:0] r;
        int          kind;
        r    = {$urandom(), $urandom()};
        kind = $urandom_range(0, 9);
        s.db = 1'($urandom_range(0, 1));
        if (kind == 0) begin
            s.f = '0; s.e = '0; s.e_z = 1'b1; s.fz = 1'b1;
            s.lz = 6'($urandom_range(0, 63));
        end else if (kind <= 4) begin
            s.e = '0; s.e_z = 1'b1; s.fz = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                s.lz = 6'($urandom_range(53, 63));
                s.f  = (r[52:0] & 53'hFF) | 53'd1;
            end else begin
                s.lz = 6'($urandom_range(0, 52));
                s.f  = (r[52:0] & ((ONE52 >> s.lz) - 53'd1)) | (ONE52 >> s.lz);
            end
        end else begin
            s.f   = r[52:0] | ONE52;
            s.e   = s.db ? 11'($urandom_range(1, 2046))
                         : {3'($urandom()), 8'($urandom_range(1, 254))};
            s.e_z = 1'b0;
            s.fz  = (s.f[51:0] == '0);
            s.lz  = '0;
        end
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.db  = s.db;
        bus.f   = s.f;
        bus.lz  = s.lz;
        bus.e   = s.e;
        bus.e_z = s.e_z;
        bus.fz  = s.fz;
    endtask

    task automatic check_result(input string tag, input res_t x);
        check({tag, "_fn"},   64'(bus.fn),   64'(x.fn));
        check({tag, "_en"},   64'(bus.en),   64'(x.en));
        check({tag, "_zero"}, 64'(bus.zero), 64'(x.zero));
    endtask

    // One transaction: accept, measure latency, check, optionally stall.
    // Called at posedge+1 with out_ready high.
    task automatic apply(input string tag, input stim_t s, input res_t x, input int stall);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        drive(s);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_latency"},   64'(n),             64'(x.lat));
        check_result(tag, x);
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            repeat (stall) begin
                @(posedge clk); #1;
                check({tag, "_stall_valid"}, 64'(bus.out_valid), 64'd1);
                check({tag, "_stall_ready"}, 64'(bus.in_ready),  64'd0);
                check_result({tag, "_stall"}, x);
            end
            bus.out_ready = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[11];
        stim_t sa, sb, s;
        res_t  xa, xb, x;

        vecs[0]  = '{"dbl_norm",   '{1'b1, ONE52, 6'd0, 11'h400, 1'b0, 1'b1}, '{ONE52, 1, 1'b0, 1}};
        vecs[1]  = '{"dbl_sub52",  '{1'b1, 53'd1, 6'd52, 11'h0, 1'b1, 1'b0}, '{ONE52, -1074, 1'b0, 5}};
        vecs[2]  = '{"sgl_sub13",  '{1'b0, ONE52 >> 13, 6'd13, 11'h0, 1'b1, 1'b0}, '{ONE52, -139, 1'b0, 2}};
        vecs[3]  = '{"dbl_zero",   '{1'b1, 53'd0, 6'd53, 11'h0, 1'b1, 1'b1}, '{53'd0, 0, 1'b1, 1}};
        vecs[4]  = '{"sgl_norm",   '{1'b0, ONE52 | 53'd5, 6'd0, 11'h7FF, 1'b0, 1'b0}, '{ONE52 | 53'd5, 128, 1'b0, 1}};
        vecs[5]  = '{"dbl_lz63",   '{1'b1, 53'd1, 6'd63, 11'h0, 1'b1, 1'b0}, '{ONE52, -1074, 1'b0, 5}};
        vecs[6]  = '{"dbl_max",    '{1'b1, ONE52 | 53'd1, 6'd0, 11'h7FE, 1'b0, 1'b0}, '{ONE52 | 53'd1, 1023, 1'b0, 1}};
        vecs[7]  = '{"dbl_sub16",  '{1'b1, ONE52 >> 16, 6'd16, 11'h0, 1'b1, 1'b0}, '{ONE52, -1038, 1'b0, 2}};
        vecs[8]  = '{"dbl_sub17",  '{1'b1, (ONE52 >> 17) | 53'd3, 6'd17, 11'h0, 1'b1, 1'b0},
                     '{53'h10000000060000, -1039, 1'b0, 3}};
        vecs[9]  = '{"sgl_zero",   '{1'b0, 53'd0, 6'd0, 11'h0, 1'b1, 1'b1}, '{53'd0, 0, 1'b1, 1}};
        vecs[10] = '{"sgl_sub23",  '{1'b0, ONE52 >> 23, 6'd23, 11'h0, 1'b1, 1'b0}, '{ONE52, -149, 1'b0, 3}};

        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive('{1'b0, 53'd0, 6'd0, 11'h0, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_fn",        64'(bus.fn),        64'd0);
        check("rst_en",        64'(bus.en),        64'd0);
        check("rst_zero",      64'(bus.zero),      64'd0);

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            x = vecs[i].x;
            if (FAST) x.lat = 1;
            apply(vecs[i].name, vecs[i].s, x, 0);
        end

        // Backpressure: A held for 3 cycles while B waits, then same-edge swap.
        @(posedge clk); #1;                    // drain to IDLE
        sa = '{1'b1, ONE52 | 53'h1234, 6'd0, 11'h3FF, 1'b0, 1'b0};
        sb = '{1'b0, ONE52 | 53'h55, 6'd0, 11'h081, 1'b0, 1'b0};
        xa = model(sa);
        xb = model(sb);
        bus.out_ready = 1'b0;
        drive(sa);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        drive(sb);
        check("bp_valid", 64'(bus.out_valid), 64'd1);
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_ready", 64'(bus.in_ready), 64'd0);
            check_result("bp_hold", xa);
            @(posedge clk); #1;
        end
        check_result("bp_hold_end", xa);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_next_valid", 64'(bus.out_valid), 64'd1);
        check_result("bp_next", xb);
        @(posedge clk); #1;

        // Reset pulsed while the lz=52 operand is in flight.
        bus.out_ready = 1'b0;
        drive(vecs[1].s);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("mid_rst_fn",        64'(bus.fn),        64'd0);
        check("mid_rst_en",        64'(bus.en),        64'd0);
        apply("post_rst", vecs[0].s, vecs[0].x, 0);

        // Random operands against the reference model.
        for (int i = 0; i < 200; i++) begin
            s = rand_stim();
            apply($sformatf("rnd%0d", i), s, model(s),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        end

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
